// File: rtl/mask_blob_tracker.sv
// Run extraction and single-blob bounding-box tracker over a per-pixel threshold mask.
module mask_blob_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             mask,
  input  logic [9:0]       tv_x,
  input  logic [9:0]       tv_y,
  input  logic [9:0]       x_max,
  input  logic [8:0]       blob_min_x,
  input  logic [8:0]       blob_min_y,
  output logic             run_valid,
  output logic [9:0]       run_x1,
  output logic [9:0]       run_x2,
  output logic [9:0]       run_y,
  output logic             blob_valid,
  input  logic             blob_ready,
  output logic [9:0]       blob_x1,
  output logic [9:0]       blob_x2,
  output logic [9:0]       blob_y1,
  output logic [9:0]       blob_y2,
  output logic [CNT_W-1:0] blob_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_stb,
  output logic             blob_ovf
);

  localparam int unsigned XW = 10;
  localparam int unsigned LW = 11;

  typedef enum logic { R_IDLE, R_IN }   run_state_t;
  typedef enum logic { B_IDLE, B_OPEN } blob_state_t;

  run_state_t  run_state, run_state_d;
  blob_state_t blob_state, blob_state_d;

  logic [XW-1:0] last_x, last_y, run_start, start_d;
  logic          eol_q, eof_q, fr_pend;
  logic          line_chg, frame_new;

  logic          cls, open_pix, run_ok;
  logic [XW-1:0] cls_x1, cls_x2, cls_y;
  logic [LW-1:0] run_len;

  logic [XW-1:0] bx1, bx2, by1, by2, nx1, nx2, ny1, ny2;
  logic          hit, hit_d, ext, open_eff, emit;
  logic [LW-1:0] height;

  assign line_chg  = pix_en && (tv_y != last_y);
  assign frame_new = line_chg && (tv_y < last_y);

  // Run FSM next state: detect run closure and where a new run starts
  always_comb begin
    run_state_d = run_state;
    start_d     = run_start;
    cls         = 1'b0;
    cls_x1      = run_start;
    cls_x2      = last_x;
    cls_y       = last_y;
    open_pix    = 1'b0;
    if (pix_en) begin
      if (run_state == R_IN) begin
        if (line_chg) begin
          cls         = 1'b1;
          run_state_d = R_IDLE;
          open_pix    = 1'b1;
        end else if (!mask) begin
          cls         = 1'b1;
          cls_y       = tv_y;
          run_state_d = R_IDLE;
        end else if (tv_x == x_max) begin
          cls         = 1'b1;
          cls_x2      = tv_x;
          cls_y       = tv_y;
          run_state_d = R_IDLE;
        end
      end else begin
        open_pix = 1'b1;
      end
      // Pixels right of the ROI edge never start a run
      if (open_pix && mask && (tv_x <= x_max)) begin
        start_d = tv_x;
        if (tv_x == x_max) begin
          // A same-cycle line-change closure takes priority over a 1-px edge run
          if (!cls) begin
            cls    = 1'b1;
            cls_x1 = tv_x;
            cls_x2 = tv_x;
            cls_y  = tv_y;
          end
          run_state_d = R_IDLE;
        end else begin
          run_state_d = R_IN;
        end
      end
    end
    run_len = LW'(cls_x2) - LW'(cls_x1) + LW'(1);
    run_ok  = cls && (run_len >= LW'(blob_min_x));
  end

  // Run FSM state, line tracking and registered run output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_state <= R_IDLE;
      run_start <= '0;
      last_x    <= '0;
      last_y    <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      fr_pend   <= 1'b0;
      run_valid <= 1'b0;
      run_x1    <= '0;
      run_x2    <= '0;
      run_y     <= '0;
    end else begin
      run_state <= run_state_d;
      run_start <= start_d;
      if (pix_en) begin
        last_x <= tv_x;
        last_y <= tv_y;
      end
      eol_q     <= line_chg;
      eof_q     <= frame_new;
      fr_pend   <= eof_q;
      run_valid <= run_ok;
      if (run_ok) begin
        run_x1 <= cls_x1;
        run_x2 <= cls_x2;
        run_y  <= cls_y;
      end
    end
  end

  // Blob FSM next state: apply this cycle's run, then evaluate end-of-line/frame closure
  always_comb begin
    blob_state_d = blob_state;
    nx1          = bx1;
    nx2          = bx2;
    ny1          = by1;
    ny2          = by2;
    hit_d        = hit;
    emit         = 1'b0;
    ext          = 1'b0;
    open_eff     = 1'b0;
    if (blob_state == B_IDLE) begin
      if (run_valid) begin
        nx1          = run_x1;
        nx2          = run_x2;
        ny1          = run_y;
        ny2          = run_y;
        hit_d        = 1'b1;
        open_eff     = 1'b1;
        blob_state_d = B_OPEN;
      end
    end else begin
      open_eff = 1'b1;
      ext = run_valid
            && ((run_y == by2) || (LW'(run_y) == LW'(by2) + LW'(1)))
            && (run_x1 <= bx2) && (run_x2 >= bx1);
      if (ext) begin
        nx1   = (run_x1 < bx1) ? run_x1 : bx1;
        nx2   = (run_x2 > bx2) ? run_x2 : bx2;
        ny2   = run_y;
        hit_d = 1'b1;
      end
    end
    height = LW'(ny2) - LW'(ny1) + LW'(1);
    if (open_eff) begin
      if (eof_q || (eol_q && !hit_d)) begin
        emit         = (height >= LW'(blob_min_y));
        hit_d        = 1'b0;
        blob_state_d = B_IDLE;
      end else if (eol_q) begin
        hit_d = 1'b0;
      end
    end
  end

  // Blob FSM state, blob output handshake and frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blob_state  <= B_IDLE;
      bx1         <= '0;
      bx2         <= '0;
      by1         <= '0;
      by2         <= '0;
      hit         <= 1'b0;
      blob_valid  <= 1'b0;
      blob_x1     <= '0;
      blob_x2     <= '0;
      blob_y1     <= '0;
      blob_y2     <= '0;
      blob_ovf    <= 1'b0;
      blob_count  <= '0;
      frame_count <= '0;
      frame_stb   <= 1'b0;
    end else begin
      blob_state <= blob_state_d;
      bx1        <= nx1;
      bx2        <= nx2;
      by1        <= ny1;
      by2        <= ny2;
      hit        <= hit_d;
      if (emit) begin
        if (blob_valid && !blob_ready) begin
          blob_ovf <= 1'b1;
        end else begin
          blob_valid <= 1'b1;
          blob_x1    <= nx1;
          blob_x2    <= nx2;
          blob_y1    <= ny1;
          blob_y2    <= ny2;
        end
      end else if (blob_valid && blob_ready) begin
        blob_valid <= 1'b0;
      end
      if (fr_pend) begin
        frame_count <= blob_count;
        blob_count  <= emit ? CNT_W'(1) : '0;
        frame_stb   <= 1'b1;
      end else begin
        frame_stb <= 1'b0;
        if (emit) blob_count <= blob_count + CNT_W'(1);
      end
    end
  end

endmodule
